// File: rtl/fetch_ctrl.sv
// Front-end sequencer: arbitrates PC redirects against load-use stalls, data-memory
// freezes and debug halt, replays redirects that arrive while fetch is held, and counts events.
module fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter int              BOOT_HOLD = 2,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trap_valid,
  input  logic             ex_redir_valid,
  input  logic [XLEN-1:0]  ex_redir_pc,
  input  logic             id_jump_valid,
  input  logic [XLEN-1:0]  id_jump_pc,
  input  logic             load_use,
  input  logic             dmem_busy,
  input  logic             dbg_halt_req,
  input  logic             dbg_resume,
  output logic             stall,
  output logic             pc_src,
  output logic [XLEN-1:0]  next_pc,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             dbg_halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  // Interface contract: trap_valid, ex_redir_valid, id_jump_valid and dbg_resume are
  // one-cycle pulses with no back-pressure, so a pulse that cannot be applied must be
  // captured the same cycle; load_use, dmem_busy and dbg_halt_req are levels sampled
  // every cycle. All fetch/pipeline controls are combinational so fetch acts at the
  // same edge.

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Numeric order is the arbitration order; P_NONE doubles as "pending empty".
  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_JUMP = 2'd1,
    P_EX   = 2'd2,
    P_TRAP = 2'd3
  } prio_t;

  localparam logic [3:0]       BOOT_LAST = 4'(BOOT_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t          state_q;
  logic [3:0]      boot_cnt_q;
  prio_t           pend_prio_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            halted_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] redir_cnt_q;

  prio_t           pulse_prio;
  logic [XLEN-1:0] pulse_pc;
  prio_t           src_prio;
  logic [XLEN-1:0] src_pc;
  logic            apply;
  logic            held;
  logic            capture;

  // Highest-priority pulse arriving this cycle.
  always_comb begin
    pulse_prio = P_NONE;
    pulse_pc   = '0;
    if (trap_valid) begin
      pulse_prio = P_TRAP;
      pulse_pc   = TRAP_VEC;
    end else if (ex_redir_valid) begin
      pulse_prio = P_EX;
      pulse_pc   = ex_redir_pc;
    end else if (id_jump_valid) begin
      pulse_prio = P_JUMP;
      pulse_pc   = id_jump_pc;
    end
  end

  // Any live pulse outranks whatever is pending, so pending only wins when no pulse is present.
  always_comb begin
    src_prio = pend_prio_q;
    src_pc   = pend_pc_q;
    if (pulse_prio != P_NONE) begin
      src_prio = pulse_prio;
      src_pc   = pulse_pc;
    end
  end

  assign apply   = (state_q == S_RUN) && !dmem_busy && (src_prio != P_NONE);
  assign held    = ((state_q == S_RUN) && dmem_busy) || (state_q == S_HALT);
  assign capture = held && (pulse_prio != P_NONE) && (pulse_prio >= pend_prio_q);

  // next_pc is driven to zero whenever no redirect is issued.
  always_comb begin
    stall       = 1'b0;
    pc_src      = 1'b0;
    next_pc     = '0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    case (state_q)
      S_RUN: begin
        if (dmem_busy) begin
          stall       = 1'b1;
          if_id_stall = 1'b1;
          pipe_freeze = 1'b1;
        end else if (src_prio != P_NONE) begin
          pc_src      = 1'b1;
          next_pc     = src_pc;
          if_id_flush = 1'b1;
          id_ex_flush = (src_prio >= P_EX);
        end else if (load_use) begin
          stall       = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      S_HALT: begin
        stall       = 1'b1;
        if_id_stall = 1'b1;
        pipe_freeze = 1'b1;
      end
      default: begin
        stall       = 1'b1;
        if_id_stall = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      pend_prio_q <= P_NONE;
      pend_pc_q   <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      case (state_q)
        S_BOOT: begin
          boot_cnt_q <= boot_cnt_q + 4'd1;
          if (boot_cnt_q == BOOT_LAST) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (apply) begin
            pend_prio_q <= P_NONE;
          end else if (capture) begin
            pend_prio_q <= pulse_prio;
            pend_pc_q   <= pulse_pc;
          end
          // A redirect in the same cycle is applied first; halt waits one cycle.
          if (!dmem_busy && !apply && dbg_halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (capture) begin
            pend_prio_q <= pulse_prio;
            pend_pc_q   <= pulse_pc;
          end
          if (dbg_resume) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_BOOT;
          halted_q <= 1'b0;
        end
      endcase

      if (stall && (state_q != S_BOOT) && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (pc_src && (redir_cnt_q != CNT_MAX)) begin
        redir_cnt_q <= redir_cnt_q + 1'b1;
      end
    end
  end

  assign dbg_halted = halted_q;
  assign stall_cnt  = stall_cnt_q;
  assign redir_cnt  = redir_cnt_q;

  a_redirect_not_stalled: assert property (@(posedge clk) disable iff (reset) pc_src |-> !stall);
  a_no_redirect_in_boot: assert property (@(posedge clk) disable iff (reset)
    (state_q == S_BOOT) |-> !pc_src);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver pushes reference-model expectations, a
// negedge monitor pops and compares the DUT outputs each cycle.
module tb_fetch_ctrl;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100;
  localparam int              BOOT_HOLD = 2;
  localparam int              CNT_W     = 6;
  localparam int              CNT_MAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic            reset;
    logic            trap;
    logic            ex;
    logic [XLEN-1:0] ex_pc;
    logic            id;
    logic [XLEN-1:0] id_pc;
    logic            load_use;
    logic            busy;
    logic            halt_req;
    logic            resume;
  } in_t;

  typedef struct packed {
    logic             stall;
    logic             pc_src;
    logic [XLEN-1:0]  next_pc;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;
    logic             dbg_halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redir_cnt;
  } out_t;

  localparam int OW = $bits(out_t);

  logic             clk;
  logic             reset;
  logic             trap_valid;
  logic             ex_redir_valid;
  logic [XLEN-1:0]  ex_redir_pc;
  logic             id_jump_valid;
  logic [XLEN-1:0]  id_jump_pc;
  logic             load_use;
  logic             dmem_busy;
  logic             dbg_halt_req;
  logic             dbg_resume;
  logic             stall;
  logic             pc_src;
  logic [XLEN-1:0]  next_pc;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             pipe_freeze;
  logic             dbg_halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redir_cnt;

  fetch_ctrl #(
    .XLEN(XLEN), .TRAP_VEC(TRAP_VEC), .BOOT_HOLD(BOOT_HOLD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .trap_valid(trap_valid),
    .ex_redir_valid(ex_redir_valid), .ex_redir_pc(ex_redir_pc),
    .id_jump_valid(id_jump_valid), .id_jump_pc(id_jump_pc),
    .load_use(load_use), .dmem_busy(dmem_busy),
    .dbg_halt_req(dbg_halt_req), .dbg_resume(dbg_resume),
    .stall(stall), .pc_src(pc_src), .next_pc(next_pc),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_freeze(pipe_freeze), .dbg_halted(dbg_halted),
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Behaviour as timeline quantities: boot cycles remaining, halted flag, one
  // pending redirect slot ranked 3=trap, 2=ex, 1=jump, and two event counters.
  int          m_boot_left, n_boot_left;
  bit          m_halted,    n_halted;
  bit          m_pv,        n_pv;
  logic [31:0] m_ppc,       n_ppc;
  int          m_prank,     n_prank;
  int          m_scnt,      n_scnt;
  int          m_rcnt,      n_rcnt;

  task automatic model_reset_vals();
    m_boot_left = BOOT_HOLD;
    m_halted    = 0;
    m_pv        = 0;
    m_ppc       = '0;
    m_prank     = 0;
    m_scnt      = 0;
    m_rcnt      = 0;
  endtask

  task automatic model_commit();
    m_boot_left = n_boot_left;
    m_halted    = n_halted;
    m_pv        = n_pv;
    m_ppc       = n_ppc;
    m_prank     = n_prank;
    m_scnt      = n_scnt;
    m_rcnt      = n_rcnt;
  endtask

  task automatic model_eval(input in_t v, output out_t o);
    int          rank;
    logic [31:0] tgt;
    o = '0;
    if (v.reset) model_reset_vals();
    rank = v.trap ? 3 : v.ex ? 2 : v.id ? 1 : 0;
    tgt  = v.trap ? TRAP_VEC : v.ex ? v.ex_pc : v.id ? v.id_pc : 32'h0;
    n_boot_left = m_boot_left;
    n_halted    = m_halted;
    n_pv        = m_pv;
    n_ppc       = m_ppc;
    n_prank     = m_prank;
    n_scnt      = m_scnt;
    n_rcnt      = m_rcnt;
    o.dbg_halted = m_halted;
    o.stall_cnt  = CNT_W'(m_scnt);
    o.redir_cnt  = CNT_W'(m_rcnt);
    if (v.reset || m_boot_left > 0) begin
      o.stall       = 1'b1;
      o.if_id_stall = 1'b1;
      if (!v.reset) n_boot_left = m_boot_left - 1;
    end else begin
      if (m_halted || v.busy) begin
        o.stall       = 1'b1;
        o.if_id_stall = 1'b1;
        o.pipe_freeze = 1'b1;
        if (rank > 0 && (!m_pv || rank >= m_prank)) begin
          n_pv    = 1;
          n_ppc   = tgt;
          n_prank = rank;
        end
        if (m_halted && v.resume) n_halted = 0;
      end else if (rank > 0 || m_pv) begin
        if (rank == 0) begin
          rank = m_prank;
          tgt  = m_ppc;
        end
        o.pc_src      = 1'b1;
        o.next_pc     = tgt;
        o.if_id_flush = 1'b1;
        o.id_ex_flush = (rank >= 2);
        n_pv          = 0;
      end else begin
        if (v.load_use) begin
          o.stall       = 1'b1;
          o.if_id_stall = 1'b1;
          o.id_ex_flush = 1'b1;
        end
        if (v.halt_req) n_halted = 1;
      end
      if (o.stall && m_scnt < CNT_MAX) n_scnt = m_scnt + 1;
      if (o.pc_src && m_rcnt < CNT_MAX) n_rcnt = m_rcnt + 1;
    end
  endtask

  // ---------------- driver ----------------
  logic [OW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  task automatic drive(input in_t v);
    out_t o;
    @(posedge clk);
    #1;
    model_commit();
    reset          = v.reset;
    trap_valid     = v.trap;
    ex_redir_valid = v.ex;
    ex_redir_pc    = v.ex_pc;
    id_jump_valid  = v.id;
    id_jump_pc     = v.id_pc;
    load_use       = v.load_use;
    dmem_busy      = v.busy;
    dbg_halt_req   = v.halt_req;
    dbg_resume     = v.resume;
    model_eval(v, o);
    exp_q.push_back(o);
  endtask

  task automatic drive_n(input in_t v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{stall, pc_src, next_pc, if_id_stall, if_id_flush, id_ex_flush,
              pipe_freeze, dbg_halted, stall_cnt, redir_cnt};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t got/exp stall=%b/%b pc_src=%b/%b next_pc=%h/%h if_id_stall=%b/%b if_id_flush=%b/%b id_ex_flush=%b/%b freeze=%b/%b halted=%b/%b stall_cnt=%0d/%0d redir_cnt=%0d/%0d",
                   $time, a.stall, e.stall, a.pc_src, e.pc_src, a.next_pc, e.next_pc,
                   a.if_id_stall, e.if_id_stall, a.if_id_flush, e.if_id_flush,
                   a.id_ex_flush, e.id_ex_flush, a.pipe_freeze, e.pipe_freeze,
                   a.dbg_halted, e.dbg_halted, a.stall_cnt, e.stall_cnt,
                   a.redir_cnt, e.redir_cnt);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t v;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    trap_valid = 0; ex_redir_valid = 0; ex_redir_pc = '0;
    id_jump_valid = 0; id_jump_pc = '0; load_use = 0; dmem_busy = 0;
    dbg_halt_req = 0; dbg_resume = 0;
    model_reset_vals();
    n_boot_left = BOOT_HOLD; n_halted = 0; n_pv = 0; n_ppc = '0; n_prank = 0;
    n_scnt = 0; n_rcnt = 0;

    // reset, then boot hold and first free-running cycles
    v = idle(); v.reset = 1'b1;
    drive_n(v, 3);
    drive_n(idle(), 4);

    // ex redirect beats id jump and load-use in the same cycle
    v = idle(); v.ex = 1; v.ex_pc = 32'h40; v.id = 1; v.id_pc = 32'h80; v.load_use = 1;
    drive(v);
    v = idle(); v.load_use = 1;
    drive(v);
    drive(idle());

    // busy window: jump then trap captured, trap replayed when busy drops
    v = idle(); v.busy = 1; v.id = 1; v.id_pc = 32'h20;
    drive(v);
    v = idle(); v.busy = 1; v.trap = 1;
    drive(v);
    v = idle(); v.busy = 1;
    drive(v);
    drive_n(idle(), 2);

    // lower rank ignored, equal rank overwrites pending
    v = idle(); v.busy = 1; v.ex = 1; v.ex_pc = 32'h44;
    drive(v);
    v = idle(); v.busy = 1; v.id = 1; v.id_pc = 32'h88;
    drive(v);
    v = idle(); v.busy = 1; v.ex = 1; v.ex_pc = 32'h99;
    drive(v);
    drive_n(idle(), 2);

    // debug halt with redirect captured while halted
    v = idle(); v.halt_req = 1;
    drive(v);
    v = idle(); v.halt_req = 1; v.ex = 1; v.ex_pc = 32'h60;
    drive(v);
    v = idle(); v.resume = 1;
    drive(v);
    drive_n(idle(), 2);

    // reset while a redirect is pending under dmem_busy
    v = idle(); v.busy = 1; v.ex = 1; v.ex_pc = 32'h60;
    drive(v);
    v = idle(); v.busy = 1; v.reset = 1;
    drive_n(v, 2);
    drive_n(idle(), 5);

    // randomized traffic, including counter saturation and occasional reset
    for (int i = 0; i < 2000; i++) begin
      v = idle();
      v.reset    = ($urandom_range(0, 299) == 0);
      v.trap     = ($urandom_range(0, 15) == 0);
      v.ex       = ($urandom_range(0, 5) == 0);
      v.ex_pc    = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      v.id       = ($urandom_range(0, 5) == 0);
      v.id_pc    = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      v.load_use = ($urandom_range(0, 3) == 0);
      v.busy     = ($urandom_range(0, 3) == 0);
      v.halt_req = ($urandom_range(0, 19) == 0);
      v.resume   = ($urandom_range(0, 7) == 0);
      drive(v);
    end
    drive_n(idle(), 2);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending expectations required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Front-end sequencer for the 5-stage pipeline, driving the fetch stage's stall/pc_src/next_pc inputs plus IF/ID and ID/EX flush/stall controls. Arbitrates PC redirect requests (trap, EX branch resolution, ID jump) against load-use stalls, data-memory freezes and debug halt. Holds redirects that arrive while fetch cannot move and replays them when it can. Also provides saturating performance counters.

Parameters:
XLEN, 32, PC/address width
TRAP_VEC, 32'h0000_0100, redirect target on trap
BOOT_HOLD, 2, cycles fetch stays stalled after reset release (1..15)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
trap_valid  in  1  single-cycle pulse, trap taken
ex_redir_valid  in  1  single-cycle pulse, EX branch mispredict/taken
ex_redir_pc  in  XLEN  EX redirect target
id_jump_valid  in  1  single-cycle pulse, ID unconditional jump
id_jump_pc  in  XLEN  ID jump target
load_use  in  1  level, load-use hazard detected in ID
dmem_busy  in  1  level, data memory not ready; whole pipe freezes
dbg_halt_req  in  1  level, request debug halt
dbg_resume  in  1  single-cycle pulse, leave halt
stall  out  1  to fetch stage: hold PC
pc_src  out  1  to fetch stage: load next_pc
next_pc  out  XLEN  to fetch stage: redirect target
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  clear IF/ID to bubble
id_ex_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  freeze ID/EX, EX/MEM, MEM/WB
dbg_halted  out  1  controller is in HALT
stall_cnt  out  CNT_W  cycles with stall=1 in RUN or HALT
redir_cnt  out  CNT_W  redirects applied

Behaviour:
- Reset: async. state=BOOT, boot counter=0, pending empty, counters=0. While in reset/BOOT: stall=1, if_id_stall=1, pc_src=0, next_pc=0, all flushes=0, pipe_freeze=0, dbg_halted=0.
- All outputs except counters and dbg_halted are combinational from state, pending register and current inputs (zero latency; fetch samples them at the same edge).
- States: BOOT, RUN, HALT.
- BOOT: counts BOOT_HOLD cycles after reset deassert, then -> RUN. Redirect pulses in BOOT are ignored.
- RUN, source priority: trap > ex_redir > id_jump > pending. Targets: TRAP_VEC, ex_redir_pc, id_jump_pc, pending_pc.
- RUN, dmem_busy=0, a redirect source active: pc_src=1, next_pc=winner target, stall=0. Flushes: trap or ex_redir -> if_id_flush=1, id_ex_flush=1; id_jump -> if_id_flush=1 only; pending -> flushes recorded at capture. Pending cleared. redir_cnt+1.
- Redirect beats load_use in the same cycle: no stall, load-use instruction squashed by the flush.
- RUN, no redirect, load_use=1, dmem_busy=0: stall=1, if_id_stall=1, id_ex_flush=1.
- RUN, dmem_busy=1: stall=1, if_id_stall=1, pipe_freeze=1, pc_src=0, no flushes. Any redirect pulse is captured into pending (pc, flush type). A new pulse overwrites pending only if its priority is >= the stored one. Pending applies on the first cycle with dmem_busy=0.
- Transitions: RUN -> HALT when dbg_halt_req=1 and dmem_busy=0, with no redirect applied that cycle (a redirect is applied first; halt follows next cycle). HALT -> RUN on dbg_resume. dbg_halted is registered and equals (state==HALT).
- HALT: stall=1, if_id_stall=1, pipe_freeze=1. Redirect pulses are captured into pending as in the dmem_busy case. Pending applies on the first RUN cycle.
- stall_cnt increments on every cycle with stall=1 in RUN or HALT (not BOOT). Both counters saturate at all-ones.
- Reset asserted mid-operation: immediate return to BOOT; pending discarded; counters cleared.

Test Plan:
- Reset, BOOT_HOLD=2 -> stall=1 for 2 cycles after reset release, then stall=0, pc_src=0; stall_cnt=0.
- RUN: ex_redir_valid=1, ex_redir_pc=0x40 together with id_jump_valid=1, id_jump_pc=0x80 and load_use=1 -> pc_src=1, next_pc=0x40, if_id_flush=1, id_ex_flush=1, stall=0; redir_cnt=1.
- RUN: load_use=1 alone for 1 cycle -> stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt=1.
- dmem_busy=1 for 3 cycles; id_jump pulse to 0x20 in cycle 1, trap pulse in cycle 2 -> no pc_src during busy. First cycle after busy drops: pc_src=1, next_pc=0x100, both flushes=1.
- dbg_halt_req=1 -> dbg_halted=1 next cycle; ex_redir pulse to 0x60 while halted; dbg_resume -> first RUN cycle pc_src=1, next_pc=0x60.
- Reset asserted while pending holds 0x60 during dmem_busy -> outputs go to reset values immediately; no redirect issued after BOOT.
